// File: rtl/mux3_sel_arbiter.sv
// Round-robin arbiter driving the SL0/SL1 selects of a shared 3:1 mux; 1-cycle request-to-grant, back-to-back hand-over.
// Optional MUX3_ARB_LOCK_EN adds a LOCK input that pins the current owner until it drops its request.
module mux3_sel_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CW        = $clog2(MAX_BURST)
) (
  input  logic       CK,
  input  logic       RST,
`ifdef MUX3_ARB_LOCK_EN
  input  logic       LOCK,
`endif
  input  logic [2:0] REQ,
  input  logic [2:0] LAST,
  output logic [2:0] GNT,
  output logic       VALID,
  output logic       SL0,
  output logic       SL1,
  output logic [1:0] OWNER
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  state_t        r_state;
  logic [2:0]    r_gnt;
  logic [1:0]    r_owner;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_sl0;
  logic          r_sl1;

  state_t        w_nxt_state;
  logic [1:0]    w_nxt_owner;
  logic [1:0]    w_nxt_ptr;
  logic [CW-1:0] w_nxt_cnt;
  logic [2:0]    w_nxt_gnt;
  logic          w_nxt_sl0;
  logic          w_nxt_sl1;

  logic [2:0]    w_own_oh;
  logic [2:0]    w_others;
  logic          w_at_max;
  logic          w_release;

  function automatic logic [1:0] f_inc3(input logic [1:0] v);
    f_inc3 = (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // First set bit of req searching ptr, ptr+1, ptr+2 (mod 3); only meaningful when req != 0.
  function automatic logic [1:0] f_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = f_inc3(ptr);
    c2 = f_inc3(c1);
    if (req[ptr])     f_pick = ptr;
    else if (req[c1]) f_pick = c1;
    else              f_pick = c2;
  endfunction

  assign w_own_oh = 3'b001 << r_owner;
  assign w_others = REQ & ~w_own_oh;
  assign w_at_max = (r_cnt == CNT_MAX);

`ifdef MUX3_ARB_LOCK_EN
  assign w_release = LOCK ? ~REQ[r_owner]
                          : (~REQ[r_owner] | LAST[r_owner] | (w_at_max & (|w_others)));
`else
  assign w_release = ~REQ[r_owner] | LAST[r_owner] | (w_at_max & (|w_others));
`endif

  // State register
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= 3'b000;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_sl0   <= 1'b0;
      r_sl1   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_owner <= w_nxt_owner;
      r_ptr   <= w_nxt_ptr;
      r_cnt   <= w_nxt_cnt;
      r_sl0   <= w_nxt_sl0;
      r_sl1   <= w_nxt_sl1;
    end
  end

  // Next-state logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|REQ) begin
          w_nxt_state = S_BUSY;
          w_nxt_owner = f_pick(REQ, r_ptr);
          w_nxt_cnt   = '0;
        end
      end
      S_BUSY: begin
        if (!w_release) begin
          if (!w_at_max) w_nxt_cnt = r_cnt + 1'b1;
        end else begin
          w_nxt_ptr = f_inc3(r_owner);
          if (|w_others) begin
            w_nxt_owner = f_pick(w_others, f_inc3(r_owner));
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Output logic: selects follow the owner even into IDLE so Z does not glitch.
  always_comb begin
    w_nxt_gnt = 3'b000;
    w_nxt_sl0 = (w_nxt_owner == 2'd1);
    w_nxt_sl1 = (w_nxt_owner == 2'd2);
    if (w_nxt_state == S_BUSY) w_nxt_gnt = 3'b001 << w_nxt_owner;
  end

  assign GNT   = r_gnt;
  assign VALID = |r_gnt;
  assign SL0   = r_sl0;
  assign SL1   = r_sl1;
  assign OWNER = r_owner;

endmodule
